// File: rtl/debug_trace_capture_if.sv
// Trace capture bus: sample stream, arm/trigger controls, readback port and status.
// Build option DEBUG_TRACE_TIMESTAMP_EN only affects what rd_ts carries, not the bus shape.
interface debug_trace_capture_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int TS_WIDTH   = 16
);
  logic                  dbg_valid;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_word;
  logic                  arm;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic [ADDR_WIDTH-1:0] trig_mask;
  logic [DEPTH_LOG2-1:0] post_count;
  logic                  rd_en;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [TS_WIDTH-1:0]   rd_ts;
  logic [1:0]            state;
  logic [DEPTH_LOG2:0]   count;
  logic                  wrapped;

  modport master (
    output dbg_valid, dbg_addr, dbg_word, arm, trig_addr, trig_mask, post_count, rd_en,
    input  rd_valid, rd_addr, rd_word, rd_ts, state, count, wrapped
  );

  modport slave (
    input  dbg_valid, dbg_addr, dbg_word, arm, trig_addr, trig_mask, post_count, rd_en,
    output rd_valid, rd_addr, rd_word, rd_ts, state, count, wrapped
  );
endinterface

// File: rtl/debug_trace_capture.sv
// Circular debug trace buffer: arm, masked-address trigger, post-trigger window, oldest-first readback.
// Capture takes one sample per cycle; readback data appears one cycle after rd_en (back-to-back capable).
// No backpressure on the sample stream; DEBUG_TRACE_TIMESTAMP_EN adds per-entry cycle timestamps.
module debug_trace_capture #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int TS_WIDTH   = 16
) (
  input logic                   clock,
  input logic                   ctrl_reset,
  debug_trace_capture_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = DEPTH[DEPTH_LOG2:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] remaining_q, remaining_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  wrapped_q, wrapped_d;
  logic                  rd_valid_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] rd_word_q;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_en, rd_fire, trig_hit;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] word_mem [DEPTH];

  assign trig_hit = ((bus.dbg_addr ^ bus.trig_addr) & bus.trig_mask) == '0;
  // Oldest entry sits count slots behind the write pointer; a full buffer maps back onto wr_ptr.
  assign rd_ptr   = wr_ptr_q - count_q[DEPTH_LOG2-1:0];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    wrapped_d   = wrapped_q;
    remaining_d = remaining_q;
    wr_en       = 1'b0;
    rd_fire     = 1'b0;
    if (bus.arm) begin
      state_d     = ARMED;
      wr_ptr_d    = '0;
      count_d     = '0;
      wrapped_d   = 1'b0;
      remaining_d = bus.post_count;
    end else begin
      case (state_q)
        ARMED, POST: begin
          if (bus.dbg_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q == FULL) wrapped_d = 1'b1;
            else                 count_d   = count_q + 1'b1;
            if (state_q == ARMED) begin
              if (trig_hit) state_d = (remaining_q == '0) ? DONE : POST;
            end else begin
              remaining_d = remaining_q - 1'b1;
              if (remaining_d == '0) state_d = DONE;
            end
          end
        end
        DONE: begin
          if (bus.rd_en && count_q != '0) begin
            rd_fire = 1'b1;
            count_d = count_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      remaining_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_word_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wrapped_q   <= wrapped_d;
      remaining_q <= remaining_d;
      rd_valid_q  <= rd_fire;
      if (rd_fire) begin
        rd_addr_q <= addr_mem[rd_ptr];
        rd_word_q <= word_mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !ctrl_reset) begin
      addr_mem[wr_ptr_q] <= bus.dbg_addr;
      word_mem[wr_ptr_q] <= bus.dbg_word;
    end
  end

`ifdef DEBUG_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] rd_ts_q;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      ts_q    <= '0;
      rd_ts_q <= '0;
    end else begin
      ts_q <= bus.arm ? '0 : ts_q + 1'b1;
      if (rd_fire) rd_ts_q <= ts_mem[rd_ptr];
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !ctrl_reset) ts_mem[wr_ptr_q] <= ts_q;
  end

  assign bus.rd_ts = rd_ts_q;
`else
  assign bus.rd_ts = {TS_WIDTH{1'b0}};
`endif

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_word  = rd_word_q;
  assign bus.state    = state_q;
  assign bus.count    = count_q;
  assign bus.wrapped  = wrapped_q;
endmodule

// File: tb/tb_debug_trace_capture.sv
// Directed bench for debug_trace_capture: capture, wrap, trigger corner cases, arm/reset priority, timestamps.
module tb_debug_trace_capture;
  logic clock;
  logic ctrl_reset;
  int   n_checks;
  int   n_errors;

  debug_trace_capture_if #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH_LOG2(4), .TS_WIDTH(16)
  ) bus ();

  debug_trace_capture #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH_LOG2(4), .TS_WIDTH(16)
  ) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] word_of(input logic [11:0] a);
    return {20'hCAFE5, a};
  endfunction

  task automatic sample(input logic [11:0] a);
    bus.dbg_valid = 1'b1;
    bus.dbg_addr  = a;
    bus.dbg_word  = word_of(a);
    tick();
    bus.dbg_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [11:0] t_addr, input logic [11:0] t_mask, input logic [3:0] post);
    bus.trig_addr  = t_addr;
    bus.trig_mask  = t_mask;
    bus.post_count = post;
    bus.arm        = 1'b1;
    tick();
    bus.arm        = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [11:0] a);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk({tag, "_vld"}, bus.rd_valid, 1'b1);
    chk({tag, "_addr"}, bus.rd_addr, a);
    chk({tag, "_word"}, bus.rd_word, word_of(a));
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    ctrl_reset     = 1'b1;
    bus.dbg_valid  = 1'b0;
    bus.dbg_addr   = '0;
    bus.dbg_word   = '0;
    bus.arm        = 1'b0;
    bus.trig_addr  = '0;
    bus.trig_mask  = '0;
    bus.post_count = '0;
    bus.rd_en      = 1'b0;
    tick();
    tick();
    ctrl_reset = 1'b0;
    chk("rst_state", bus.state, 2'd0);
    chk("rst_count", bus.count, 5'd0);
    chk("rst_wrapped", bus.wrapped, 1'b0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_rd_addr", bus.rd_addr, 12'h000);
    chk("rst_rd_ts", bus.rd_ts, 16'h0000);

    // IDLE ignores both samples and pops
    sample(12'h010);
    chk("idle_count", bus.count, 5'd0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("idle_rd_valid", bus.rd_valid, 1'b0);

    // Basic capture with two post-trigger samples
    do_arm(12'h010, 12'hFFF, 4'd2);
    chk("t1_armed", bus.state, 2'd1);
    chk("t1_count0", bus.count, 5'd0);
    sample(12'h00C);
    sample(12'h00D);
    chk("t1_pre_state", bus.state, 2'd1);
    sample(12'h010);
    chk("t1_post_state", bus.state, 2'd2);
    sample(12'h011);
    chk("t1_post_state2", bus.state, 2'd2);
    sample(12'h012);
    chk("t1_done", bus.state, 2'd3);
    chk("t1_count", bus.count, 5'd5);
    sample(12'h013);
    chk("t1_count_frozen", bus.count, 5'd5);
    chk("t1_wrapped", bus.wrapped, 1'b0);
    bus.rd_en = 1'b1;
    tick();
    chk("t1_b2b0_vld", bus.rd_valid, 1'b1);
    chk("t1_b2b0_addr", bus.rd_addr, 12'h00C);
    tick();
    bus.rd_en = 1'b0;
    chk("t1_b2b1_vld", bus.rd_valid, 1'b1);
    chk("t1_b2b1_addr", bus.rd_addr, 12'h00D);
    chk("t1_b2b1_word", bus.rd_word, word_of(12'h00D));
    tick();
    chk("t1_pulse", bus.rd_valid, 1'b0);
    chk("t1_hold", bus.rd_addr, 12'h00D);
    pop_chk("t1_p2", 12'h010);
    pop_chk("t1_p3", 12'h011);
    pop_chk("t1_p4", 12'h012);
    chk("t1_empty", bus.count, 5'd0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("t1_pop_empty", bus.rd_valid, 1'b0);
    chk("t1_still_done", bus.state, 2'd3);

    // Wrap: 20 non-matching samples then the trigger with no post window
    do_arm(12'h100, 12'hF00, 4'd0);
    for (int i = 0; i < 20; i++) begin
      sample(12'(i));
      if (i == 15) begin
        chk("t2_full", bus.count, 5'd16);
        chk("t2_not_wrapped", bus.wrapped, 1'b0);
      end
    end
    chk("t2_wrapped_early", bus.wrapped, 1'b1);
    chk("t2_armed", bus.state, 2'd1);
    sample(12'h100);
    chk("t2_done", bus.state, 2'd3);
    chk("t2_count", bus.count, 5'd16);
    chk("t2_wrapped", bus.wrapped, 1'b1);
    for (int i = 5; i < 20; i++) pop_chk("t2_pop", 12'(i));
    pop_chk("t2_last", 12'h100);
    chk("t2_empty", bus.count, 5'd0);

    // Zero mask triggers on the first sample
    do_arm(12'h555, 12'h000, 4'd3);
    chk("t3_wrapped_clr", bus.wrapped, 1'b0);
    sample(12'h0A0);
    chk("t3_post", bus.state, 2'd2);
    sample(12'h0A1);
    sample(12'h0A2);
    chk("t3_post3", bus.state, 2'd2);
    sample(12'h0A3);
    chk("t3_done", bus.state, 2'd3);
    chk("t3_count", bus.count, 5'd4);

    // arm mid-POST with a coincident sample drops that sample
    do_arm(12'h050, 12'hFFF, 4'd3);
    sample(12'h04F);
    sample(12'h050);
    sample(12'h051);
    chk("t4_post", bus.state, 2'd2);
    bus.trig_mask  = 12'h000;
    bus.post_count = 4'd1;
    bus.arm        = 1'b1;
    bus.dbg_valid  = 1'b1;
    bus.dbg_addr   = 12'h0EE;
    bus.dbg_word   = word_of(12'h0EE);
    tick();
    bus.arm       = 1'b0;
    bus.dbg_valid = 1'b0;
    chk("t4_rearmed", bus.state, 2'd1);
    chk("t4_count0", bus.count, 5'd0);
    sample(12'h060);
    sample(12'h061);
    chk("t4_done", bus.state, 2'd3);
    chk("t4_count", bus.count, 5'd2);
    pop_chk("t4_p0", 12'h060);
    pop_chk("t4_p1", 12'h061);

    // Reset between back-to-back pops
    do_arm(12'h000, 12'h000, 4'd2);
    sample(12'h070);
    sample(12'h071);
    sample(12'h072);
    chk("t5_count", bus.count, 5'd3);
    bus.rd_en = 1'b1;
    tick();
    chk("t5_first_vld", bus.rd_valid, 1'b1);
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    bus.rd_en  = 1'b0;
    chk("t5_state", bus.state, 2'd0);
    chk("t5_count0", bus.count, 5'd0);
    chk("t5_rd_valid", bus.rd_valid, 1'b0);
    chk("t5_rd_addr", bus.rd_addr, 12'h000);

    // Timestamps: counter is 0 in the cycle after arm; samples presented at counts 3 and 7
    do_arm(12'h000, 12'h000, 4'd1);
    tick();
    tick();
    tick();
    sample(12'h080);
    tick();
    tick();
    tick();
    sample(12'h081);
    chk("t6_done", bus.state, 2'd3);
    bus.rd_en = 1'b1;
    tick();
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    chk("t6_ts0", bus.rd_ts, 16'd3);
`else
    chk("t6_ts0", bus.rd_ts, 16'd0);
`endif
    chk("t6_addr0", bus.rd_addr, 12'h080);
    tick();
    bus.rd_en = 1'b0;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    chk("t6_ts1", bus.rd_ts, 16'd7);
`else
    chk("t6_ts1", bus.rd_ts, 16'd0);
`endif
    chk("t6_addr1", bus.rd_addr, 12'h081);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
